smvm_row_sequencer: RTL and testbench

Controller that feeds the sparse-row multiply-accumulate datapath. It accepts a stream of sparse-matrix rows (one header word pair followed by column word pairs) through a valid/ready input and buffers each row locally. It then replays the row into the row accumulator as one uninterrupted burst: header with `compute_start`, then one column per cycle. It captures the finished sum and row number, and presents them on a valid/ready result port.

---
 rtl/smvm_row_sequencer_if.sv | 43 ++++
 rtl/smvm_row_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_smvm_row_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smvm_row_sequencer_if.sv
// Bus bundle for the sparse-row sequencer: the input pair stream, the
// accumulator drive/return lines and the result handshake.
// 'master' is the sequencer's view; 'slave' is the surrounding system's view
// (stream source, accumulator and result consumer).
interface smvm_row_sequencer_if;
   // Input word-pair stream
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;

   // Accumulator drive and return
   logic [31:0] acc_data_a;
   logic [31:0] acc_data_b;
   logic        acc_compute_start;
   logic [31:0] acc_accum;
   logic [31:0] acc_row_num;
   logic        acc_done;

   // Result handshake
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_row;
   logic [31:0] res_value;

   modport master (
      input  in_valid, in_a, in_b,
      input  acc_accum, acc_row_num, acc_done,
      input  res_ready,
      output in_ready,
      output acc_data_a, acc_data_b, acc_compute_start,
      output res_valid, res_row, res_value
   );

   modport slave (
      output in_valid, in_a, in_b,
      output acc_accum, acc_row_num, acc_done,
      output res_ready,
      input  in_ready,
      input  acc_data_a, acc_data_b, acc_compute_start,
      input  res_valid, res_row, res_value
   );
endinterface

// File: rtl/smvm_row_sequencer.sv
// Sparse-row sequencer: buffers one row (header + column pairs) from the input
// stream, replays it to the row accumulator as a single stall-free burst,
// then holds the accumulator's result on a valid/ready port.
// Rows never overlap: input is closed from ISSUE until the result is retired.
module smvm_row_sequencer #(
   parameter int unsigned MAX_COLS = 16,
   parameter int unsigned CW       = 5
) (
   input  logic                        clk,
   input  logic                        rst_l,
   smvm_row_sequencer_if.master        bus,
   output logic                        busy,
   output logic                        err_overflow,
   output logic [31:0]                 rows_done
);

   localparam int unsigned IW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDrop,
      StIssue,
      StBurst,
      StWait,
      StResult
   } state_e;

   state_e        state_q;
   logic [31:0]   row_q;
   logic [CW-1:0] ncols_q;
   logic [CW-1:0] k_q;
   logic [31:0]   drop_q;
   logic          in_ready_q;
   logic [31:0]   acc_a_q;
   logic [31:0]   acc_b_q;
   logic          acc_start_q;
   logic          res_valid_q;
   logic [31:0]   res_row_q;
   logic [31:0]   res_value_q;
   logic          err_q;
   logic [31:0]   rows_q;

   // Column buffer: {column index, value} per slot; contents are don't-care
   // after reset, so it carries no reset.
   logic [63:0]   col_buf [MAX_COLS];
   logic [63:0]   rd_word;
   logic          in_fire;
   logic          buf_we;

   assign in_fire = bus.in_valid & in_ready_q;
   assign buf_we  = in_fire & (state_q == StLoad);
   assign rd_word = col_buf[k_q[IW-1:0]];

   // Capture column pairs into slot k during LOAD
   always_ff @(posedge clk) begin
      if (buf_we) begin
         col_buf[k_q[IW-1:0]] <= {bus.in_a, bus.in_b};
      end
   end

   // Row FSM with registered handshake, accumulator and result outputs
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= StIdle;
         row_q       <= '0;
         ncols_q     <= '0;
         k_q         <= '0;
         drop_q      <= '0;
         in_ready_q  <= 1'b0;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         acc_start_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_row_q   <= '0;
         res_value_q <= '0;
         err_q       <= 1'b0;
         rows_q      <= '0;
      end else begin
         // Accumulator lines idle at zero unless a state below drives them
         acc_start_q <= 1'b0;
         acc_a_q     <= '0;
         acc_b_q     <= '0;

         unique case (state_q)
            StIdle: begin
               in_ready_q <= 1'b1;
               if (in_fire) begin
                  row_q <= bus.in_a;
                  k_q   <= '0;
                  if (bus.in_b > 32'(MAX_COLS)) begin
                     // Row too long to buffer: swallow its columns, no result
                     err_q   <= 1'b1;
                     drop_q  <= bus.in_b;
                     state_q <= StDrop;
                  end else if (bus.in_b == 32'd0) begin
                     ncols_q     <= '0;
                     in_ready_q  <= 1'b0;
                     acc_start_q <= 1'b1;
                     acc_a_q     <= bus.in_a;
                     acc_b_q     <= '0;
                     state_q     <= StIssue;
                  end else begin
                     ncols_q <= bus.in_b[CW-1:0];
                     state_q <= StLoad;
                  end
               end
            end

            StLoad: begin
               if (in_fire) begin
                  k_q <= k_q + CW'(1);
                  if (k_q + CW'(1) == ncols_q) begin
                     // Last column buffered: header goes out next cycle
                     k_q         <= '0;
                     in_ready_q  <= 1'b0;
                     acc_start_q <= 1'b1;
                     acc_a_q     <= row_q;
                     acc_b_q     <= 32'(ncols_q);
                     state_q     <= StIssue;
                  end
               end
            end

            StDrop: begin
               if (in_fire) begin
                  drop_q <= drop_q - 32'd1;
                  if (drop_q == 32'd1) begin
                     state_q <= StIdle;
                  end
               end
            end

            StIssue: begin
               if (ncols_q == '0) begin
                  state_q <= StWait;
               end else begin
                  acc_a_q <= rd_word[63:32];
                  acc_b_q <= rd_word[31:0];
                  k_q     <= k_q + CW'(1);
                  state_q <= StBurst;
               end
            end

            StBurst: begin
               // The accumulator cannot stall, so one slot goes out every cycle
               if (k_q == ncols_q) begin
                  state_q <= StWait;
               end else begin
                  acc_a_q <= rd_word[63:32];
                  acc_b_q <= rd_word[31:0];
                  k_q     <= k_q + CW'(1);
               end
            end

            StWait: begin
               if (bus.acc_done) begin
                  res_value_q <= bus.acc_accum;
                  res_row_q   <= bus.acc_row_num;
                  res_valid_q <= 1'b1;
                  state_q     <= StResult;
               end
            end

            StResult: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  rows_q      <= rows_q + 32'd1;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.acc_data_a        = acc_a_q;
   assign bus.acc_data_b        = acc_b_q;
   assign bus.acc_compute_start = acc_start_q;
   assign bus.res_valid         = res_valid_q;
   assign bus.res_row           = res_row_q;
   assign bus.res_value         = res_value_q;

   assign busy         = (state_q != StIdle);
   assign err_overflow = err_q;
   assign rows_done    = rows_q;

endmodule

// File: tb/tb_smvm_row_sequencer.sv
// Bench for smvm_row_sequencer: a behavioural accumulator (ROM[i] = i) sits
// on the accumulator port; stimulus pushes expected accumulator traffic and
// results into queues, and a negedge monitor pops and compares them.
module tb_smvm_row_sequencer;

   localparam int MAXC = 16;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst_l = 1'b1;
   logic        busy;
   logic        err_overflow;
   logic [31:0] rows_done;

   smvm_row_sequencer_if bus ();

   smvm_row_sequencer #(
      .MAX_COLS(16),
      .CW      (5)
   ) dut (
      .clk         (clk),
      .rst_l       (rst_l),
      .bus         (bus),
      .busy        (busy),
      .err_overflow(err_overflow),
      .rows_done   (rows_done)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   pair_t       exp_acc[$];
   pair_t       exp_res[$];
   logic        model_err = 1'b0;
   int          retired = 0;
   logic [31:0] col_a [32];
   logic [31:0] col_b [32];
   logic        rr_force = 1'b1;
   logic        rr_val = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Accumulator stand-in: sums value*ROM[col], ROM[i]=i; done two cycles
   // after the last column, 1 whenever idle.
   logic [31:0] m_sum, m_row, m_cnt;
   logic        m_pend, m_done;
   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         m_sum <= '0; m_row <= '0; m_cnt <= '0; m_pend <= 1'b0; m_done <= 1'b1;
      end else if (bus.acc_compute_start) begin
         m_row <= bus.acc_data_a; m_cnt <= bus.acc_data_b; m_sum <= '0;
         m_pend <= 1'b1; m_done <= 1'b0;
      end else if (m_pend) begin
         if (m_cnt != 0) begin
            m_sum <= m_sum + {22'b0, bus.acc_data_a[9:0]} * bus.acc_data_b;
            m_cnt <= m_cnt - 32'd1;
         end else begin
            m_pend <= 1'b0;
            m_done <= 1'b1;
         end
      end
   end
   assign bus.acc_accum   = m_sum;
   assign bus.acc_row_num = m_row;
   assign bus.acc_done    = m_done;

   // Result consumer
   initial begin
      bus.res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.res_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: accumulator traffic, result handshake, status outputs
   initial begin
      int          burst_left;
      int          t_start;
      int          n_last;
      logic        prev_valid;
      logic        hold;
      logic [31:0] hold_row, hold_val;
      pair_t       e;
      burst_left = 0; t_start = 0; n_last = 0; prev_valid = 0; hold = 0;
      hold_row = 0; hold_val = 0;
      forever begin
         @(negedge clk);
         if (!rst_l) begin
            burst_left = 0; prev_valid = 0; hold = 0;
         end else begin
            if (bus.acc_compute_start) begin
               chk("start_inside_burst", 32'(burst_left), 32'd0);
               chk("in_ready_issue", 32'(bus.in_ready), 32'd0);
               if (exp_acc.size() == 0) fail_now("unexpected compute_start");
               else begin
                  e = exp_acc.pop_front();
                  chk("hdr_row", bus.acc_data_a, e.a);
                  chk("hdr_ncols", bus.acc_data_b, e.b);
                  burst_left = int'(e.b);
                  n_last = int'(e.b);
                  t_start = cyc;
               end
            end else if (burst_left > 0) begin
               chk("in_ready_burst", 32'(bus.in_ready), 32'd0);
               if (exp_acc.size() == 0) fail_now("unexpected burst column");
               else begin
                  e = exp_acc.pop_front();
                  chk("col_index", bus.acc_data_a, e.a);
                  chk("col_value", bus.acc_data_b, e.b);
               end
               burst_left--;
            end else begin
               chk("acc_idle_a", bus.acc_data_a, 32'd0);
               chk("acc_idle_b", bus.acc_data_b, 32'd0);
            end

            if (hold) begin
               chk("res_valid_held", 32'(bus.res_valid), 32'd1);
               chk("res_row_stable", bus.res_row, hold_row);
               chk("res_value_stable", bus.res_value, hold_val);
            end
            if (bus.res_valid) chk("in_ready_result", 32'(bus.in_ready), 32'd0);
            if (bus.res_valid && !prev_valid)
               chk("res_latency", 32'(cyc - t_start), 32'(n_last + 3));
            chk("rows_done", rows_done, 32'(retired));
            chk("err_overflow", 32'(err_overflow), 32'(model_err));

            hold = bus.res_valid && !bus.res_ready;
            hold_row = bus.res_row;
            hold_val = bus.res_value;
            if (bus.res_valid && bus.res_ready) begin
               if (exp_res.size() == 0) fail_now("unexpected result");
               else begin
                  e = exp_res.pop_front();
                  chk("res_row", bus.res_row, e.a);
                  chk("res_value", bus.res_value, e.b);
               end
               retired++;
            end
            prev_valid = bus.res_valid;
         end
      end
   end

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
      logic ok;
      int   n;
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      ok = 1'b0;
      n = 0;
      while (!ok && n < 400) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) fail_now("input handshake timeout");
   endtask

   task automatic idle(input int c);
      bus.in_valid = 1'b0;
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill_cols(input int n);
      for (int i = 0; i < n; i++) begin
         col_a[i] = $urandom;
         col_b[i] = $urandom_range(0, 65535);
      end
   endtask

   // gap_mode: 0 none, 1 random gaps, 2 two idle cycles after the first column
   task automatic send_row(input logic [31:0] row, input int n, input int gap_mode);
      logic [31:0] sum;
      pair_t       p;
      sum = '0;
      if (n <= MAXC) begin
         p.a = row; p.b = 32'(n);
         exp_acc.push_back(p);
         for (int i = 0; i < n; i++) begin
            p.a = col_a[i]; p.b = col_b[i];
            exp_acc.push_back(p);
            sum = sum + (col_a[i] & 32'h3ff) * col_b[i];
         end
         p.a = row; p.b = sum;
         exp_res.push_back(p);
      end
      send_pair(row, 32'(n));
      if (n > MAXC) model_err = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (gap_mode == 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if (gap_mode == 2 && i == 1) idle(2);
         send_pair(col_a[i], col_b[i]);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_res.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("drain timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_acc_a"}, bus.acc_data_a, 32'd0);
      chk({tag, "_acc_b"}, bus.acc_data_b, 32'd0);
      chk({tag, "_acc_start"}, 32'(bus.acc_compute_start), 32'd0);
      chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({tag, "_res_row"}, bus.res_row, 32'd0);
      chk({tag, "_res_value"}, bus.res_value, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err_overflow), 32'd0);
      chk({tag, "_rows_done"}, rows_done, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      #1 rst_l = 1'b0;
      #1 check_reset_values("reset");
      repeat (2) @(posedge clk);
      #3 rst_l = 1'b1;
      @(posedge clk);
      #1 chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

      // Single row: (2,5),(0,1),(9,2) -> 28
      col_a[0] = 2; col_b[0] = 5;
      col_a[1] = 0; col_b[1] = 1;
      col_a[2] = 9; col_b[2] = 2;
      send_row(32'd7, 3, 0);
      wait_idle();

      // Empty row
      send_row(32'd4, 0, 0);
      wait_idle();

      // Input gaps during LOAD
      fill_cols(4);
      send_row(32'd11, 4, 2);
      wait_idle();

      // Result back-pressure for 5 cycles
      rr_val = 1'b0;
      fill_cols(3);
      send_row(32'd12, 3, 0);
      n = 0;
      while (!bus.res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("res_valid timeout");
      repeat (5) @(posedge clk);
      rr_val = 1'b1;
      wait_idle();

      // Overflow row is dropped, next row still correct
      fill_cols(17);
      send_row(32'd99, 17, 0);
      col_a[0] = 3; col_b[0] = 4;
      send_row(32'd1, 1, 0);
      wait_idle();

      // Full row
      fill_cols(16);
      send_row(32'd21, 16, 0);
      wait_idle();

      // Random back-to-back rows with gaps and random result back-pressure
      rr_force = 1'b0;
      repeat (40) begin
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20))
                                         : int'($urandom_range(0, 16));
         fill_cols(n);
         send_row($urandom, n, 1);
      end
      wait_idle();
      rr_force = 1'b1;
      rr_val = 1'b1;

      // Reset in the middle of a burst
      fill_cols(10);
      send_row(32'd33, 10, 0);
      n = 0;
      while (!bus.acc_compute_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("compute_start timeout");
      repeat (3) @(posedge clk);
      #3;
      rst_l = 1'b0;
      exp_acc.delete();
      exp_res.delete();
      model_err = 1'b0;
      retired = 0;
      #1 check_reset_values("midreset");
      repeat (2) @(posedge clk);
      #3 rst_l = 1'b1;
      @(posedge clk);
      #1;
      fill_cols(5);
      send_row(32'd8, 5, 0);
      wait_idle();
      chk("rows_done_after_reset", rows_done, 32'd1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
